// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared character-class and state encodings for the identifier stages
package id_pkg;

  typedef enum logic [1:0] {
    CC_NONE   = 2'd0,
    CC_LETTER = 2'd1,
    CC_DIGIT  = 2'd2,
    CC_OTHER  = 2'd3
  } char_class_e;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_GAP  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic logic is_alnum(input char_class_e cls);
    return (cls == CC_LETTER) || (cls == CC_DIGIT);
  endfunction

endpackage

// File: rtl/char_class.sv
// rtl/char_class.sv - combinational ASCII character classifier
module char_class
  import id_pkg::*;
(
  input  logic [7:0]  char,
  output char_class_e cls
);

  always_comb begin
    cls = CC_OTHER;
    if ((char >= 8'h61 && char <= 8'h7a) || (char >= 8'h41 && char <= 8'h5a))
      cls = CC_LETTER;
    else if (char >= 8'h30 && char <= 8'h39)
      cls = CC_DIGIT;
  end

endmodule

// File: rtl/id_token_counter.sv
// rtl/id_token_counter.sv - counts accepted identifier tokens and tracks their lengths
module id_token_counter
  import id_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             match,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] count,
  output logic [LEN_W-1:0] last_len,
  output logic [LEN_W-1:0] max_len
);

  char_class_e      cls;
  state_e           state;
  logic [LEN_W-1:0] run_len;
  logic             alnum;
  logic             token_end;

  char_class u_char_class (
    .char (char),
    .cls  (cls)
  );

  assign alnum     = is_alnum(cls);
  assign token_end = (state == ST_RUN) && !alnum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_SYNC;
      run_len  <= '0;
      hit      <= 1'b0;
      count    <= '0;
      last_len <= '0;
      max_len  <= '0;
    end else begin
      // SYNC drops whatever token straddled the reset until a separator is seen
      case (state)
        ST_SYNC: begin
          if (!alnum) state <= ST_GAP;
        end
        ST_GAP: begin
          if (alnum) begin
            state   <= ST_RUN;
            run_len <= LEN_W'(1);
          end
        end
        ST_RUN: begin
          if (alnum) begin
            if (run_len != '1) run_len <= run_len + LEN_W'(1);
          end else begin
            state   <= ST_GAP;
            run_len <= '0;
          end
        end
        default: begin
          state   <= ST_SYNC;
          run_len <= '0;
        end
      endcase

      hit <= 1'b0;
      if (clr) begin
        count    <= '0;
        last_len <= '0;
        max_len  <= '0;
      end else if (token_end && match) begin
        hit      <= 1'b1;
        last_len <= run_len;
        if (count != '1) count <= count + CNT_W'(1);
        if (run_len > max_len) max_len <= run_len;
      end
    end
  end

endmodule
